nina_prog_bridge: RTL and testbench

//  Parametrised ESP32 programming/console bridge for the NINA path: muxes one header UART to N_TARGETS ESP32 targets
//  and owns each target's EN (reset) and IO0 (strap) lines through a timed reset/boot sequencer instead of raw wires.

---
 rtl/nina_prog_pkg.sv | 26 ++
 rtl/prog_debounce.sv | 38 +++
 rtl/nina_prog_bridge.sv | 178 +++++++++++++++++
 tb/tb_nina_prog_bridge.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nina_prog_pkg.sv
// Shared types and constants for the NINA programming bridge.
// Holds the sequencer state encoding and the header mode values.
package nina_prog_pkg;

  typedef enum logic [1:0] {
    ST_RST_ASSERT = 2'd0,
    ST_BOOT_HOLD  = 2'd1,
    ST_IDLE       = 2'd2
  } state_t;

  localparam logic [1:0] MODE_MANUAL = 2'd0;
  localparam logic [1:0] MODE_AUTO   = 2'd1;
  localparam logic [1:0] MODE_LOCKED = 2'd2;

  // Only manual and auto modes may start a sequence; both locked encodings block triggers.
  function automatic logic mode_triggers(input logic [1:0] mode);
    logic ok;
    case (mode)
      MODE_MANUAL, MODE_AUTO: ok = 1'b1;
      MODE_LOCKED:            ok = 1'b0;
      default:                ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/prog_debounce.sv
// Button conditioner: 2-FF synchroniser followed by a stability counter.
// The debounced level changes only after the input has differed from it for DEBOUNCE_CYC cycles.
module prog_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 480000
) (
  input  logic iCLK,
  input  logic iRESETn,
  input  logic iBTN,
  output logic oLEVEL
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYC) + 1;

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q;
  logic             level_q;

  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      sync_q  <= 2'b00;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], iBTN};
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
        level_q <= sync_q[1];
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign oLEVEL = level_q;

endmodule

// File: rtl/nina_prog_bridge.sv
// ESP32 programming/console bridge: header UART mux plus a timed EN/IO0 reset and boot sequencer
// triggered by debounced buttons or esptool-style DTR/RTS activity.
module nina_prog_bridge
  import nina_prog_pkg::*;
#(
  parameter int unsigned N_TARGETS     = 1,
  parameter int unsigned SEL_W         = 3,
  parameter int unsigned DEBOUNCE_CYC  = 480000,
  parameter int unsigned RST_PULSE_CYC = 4800000,
  parameter int unsigned BOOT_HOLD_CYC = 2400000
) (
  input  logic                 iCLK,
  input  logic                 iRESETn,
  input  logic [1:0]           iMODE,
  input  logic [SEL_W-1:0]     iSEL,
  input  logic                 iRESET_BTN,
  input  logic                 iBOOT_BTN,
  input  logic                 iHDR_RX,
  input  logic                 iHDR_DTRn,
  input  logic                 iHDR_RTSn,
  output logic                 oHDR_TX,
  input  logic [N_TARGETS-1:0] iESP_TX,
  output logic [N_TARGETS-1:0] oESP_RX,
  output logic [N_TARGETS-1:0] oESP_EN,
  output logic [N_TARGETS-1:0] oESP_IO0,
  output logic                 oBUSY,
  output logic                 oBOOTED_DL
);

  localparam int unsigned MAX_CYC = (RST_PULSE_CYC > BOOT_HOLD_CYC) ? RST_PULSE_CYC : BOOT_HOLD_CYC;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;

  logic rst_lvl, boot_lvl, rst_prev_q;
  logic [1:0] dtr_sync_q, rts_sync_q;
  logic rts_prev_q;
  logic dtr_act, rts_act, rst_press, rts_rise;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             boot_f_q, boot_f_d, auto_f_q, auto_f_d, por_q, por_d;
  logic [SEL_W-1:0] sel_q, sel_d;

  logic [N_TARGETS-1:0] en_q, en_d, io0_q, io0_d;
  logic                 busy_q, booted_q, booted_d;

  prog_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_rst_db (
    .iCLK(iCLK), .iRESETn(iRESETn), .iBTN(iRESET_BTN), .oLEVEL(rst_lvl)
  );

  prog_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_boot_db (
    .iCLK(iCLK), .iRESETn(iRESETn), .iBTN(iBOOT_BTN), .oLEVEL(boot_lvl)
  );

  assign dtr_act   = ~dtr_sync_q[1];
  assign rts_act   = ~rts_sync_q[1];
  assign rst_press = rst_lvl & ~rst_prev_q;
  assign rts_rise  = rts_act & ~rts_prev_q;

  // Header handshake synchronisers and edge-detect history; lines idle high.
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      dtr_sync_q <= 2'b11;
      rts_sync_q <= 2'b11;
      rts_prev_q <= 1'b0;
      rst_prev_q <= 1'b0;
    end else begin
      dtr_sync_q <= {dtr_sync_q[0], iHDR_DTRn};
      rts_sync_q <= {rts_sync_q[0], iHDR_RTSn};
      rts_prev_q <= rts_act;
      rst_prev_q <= rst_lvl;
    end
  end

  // Sequencer next-state; the shared counter restarts from zero on every state change.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    boot_f_d = boot_f_q;
    auto_f_d = auto_f_q;
    por_d    = por_q;
    sel_d    = sel_q;
    case (state_q)
      ST_IDLE: begin
        sel_d = iSEL;
        if (mode_triggers(iMODE) && rst_press) begin
          state_d  = ST_RST_ASSERT;
          boot_f_d = boot_lvl;
          auto_f_d = 1'b0;
        end else if (iMODE == MODE_AUTO && rts_rise) begin
          state_d  = ST_RST_ASSERT;
          boot_f_d = 1'b0;
          auto_f_d = 1'b1;
        end
      end
      ST_RST_ASSERT: begin
        if (cnt_q != CNT_W'(RST_PULSE_CYC - 1)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else if (!auto_f_q || !rts_act) begin
          if (auto_f_q) boot_f_d = dtr_act;
          state_d = boot_f_d ? ST_BOOT_HOLD : ST_IDLE;
          por_d   = 1'b0;
        end
      end
      ST_BOOT_HOLD: begin
        if (cnt_q == CNT_W'(BOOT_HOLD_CYC - 1)) state_d = ST_IDLE;
        else                                     cnt_d   = cnt_q + CNT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
    if (state_d == ST_IDLE) auto_f_d = 1'b0;
  end

  // Pin values are derived from the next state so EN/IO0 move on the first cycle of each state.
  always_comb begin
    en_d  = '1;
    io0_d = '1;
    for (int i = 0; i < int'(N_TARGETS); i++) begin
      if (state_d == ST_RST_ASSERT && por_d) begin
        en_d[i] = 1'b0;
      end else if (sel_d == SEL_W'(i)) begin
        case (state_d)
          ST_RST_ASSERT: begin
            en_d[i]  = 1'b0;
            io0_d[i] = auto_f_d ? ~dtr_act : ~boot_f_d;
          end
          ST_BOOT_HOLD: io0_d[i] = 1'b0;
          default: ;
        endcase
      end
    end
    booted_d = (state_d == ST_IDLE && state_q != ST_IDLE) ? boot_f_d : booted_q;
  end

  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      state_q  <= ST_RST_ASSERT;
      cnt_q    <= '0;
      boot_f_q <= 1'b0;
      auto_f_q <= 1'b0;
      por_q    <= 1'b1;
      sel_q    <= '0;
      en_q     <= '0;
      io0_q    <= '1;
      busy_q   <= 1'b1;
      booted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      boot_f_q <= boot_f_d;
      auto_f_q <= auto_f_d;
      por_q    <= por_d;
      sel_q    <= sel_d;
      en_q     <= en_d;
      io0_q    <= io0_d;
      busy_q   <= (state_d != ST_IDLE);
      booted_q <= booted_d;
    end
  end

  // UART data path is a plain mux; an out-of-range select parks every line idle-high.
  always_comb begin
    oHDR_TX = 1'b1;
    oESP_RX = '1;
    for (int i = 0; i < int'(N_TARGETS); i++) begin
      if (sel_q == SEL_W'(i)) begin
        oHDR_TX    = iESP_TX[i];
        oESP_RX[i] = iHDR_RX;
      end
    end
  end

  assign oESP_EN    = en_q;
  assign oESP_IO0   = io0_q;
  assign oBUSY      = busy_q;
  assign oBOOTED_DL = booted_q;

endmodule

// File: tb/tb_nina_prog_bridge.sv
// Bench for nina_prog_bridge: vector table of trigger scenarios, a completion monitor that
// scores each finished sequence against queued expectations, and hand-written corner sequences.
module tb_nina_prog_bridge;

  localparam int NT = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    mode;
  logic [2:0]    sel;
  logic          rst_btn, boot_btn, hdr_rx, dtrn, rtsn;
  logic          hdr_tx;
  logic [NT-1:0] esp_tx, esp_rx, esp_en, esp_io0;
  logic          busy, booted;

  nina_prog_bridge #(
    .N_TARGETS(NT), .SEL_W(3), .DEBOUNCE_CYC(8), .RST_PULSE_CYC(20), .BOOT_HOLD_CYC(10)
  ) dut (
    .iCLK(clk), .iRESETn(rst_n), .iMODE(mode), .iSEL(sel),
    .iRESET_BTN(rst_btn), .iBOOT_BTN(boot_btn), .iHDR_RX(hdr_rx),
    .iHDR_DTRn(dtrn), .iHDR_RTSn(rtsn), .oHDR_TX(hdr_tx),
    .iESP_TX(esp_tx), .oESP_RX(esp_rx), .oESP_EN(esp_en), .oESP_IO0(esp_io0),
    .oBUSY(busy), .oBOOTED_DL(booted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NT-1:0][7:0] en_low;
    logic [NT-1:0][7:0] io0_low;
    logic [7:0]         busy_len;
    logic               booted;
  } exp_t;

  typedef struct {
    logic [1:0] mode;
    logic [2:0] sel;
    bit         boot;
    int         press;
    int         rts;
    bit         dtr;
    int         seq;
    int         en;
    int         io0;
    int         busy_len;
    bit         booted;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];
  vec_t cv;
  exp_t exp_q [$];
  exp_t e;

  int n_tests = 0;
  int n_fail  = 0;
  int n_seq   = 0;
  int n_before;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_busy(input logic val, input int max_cyc, input string name);
    int k = 0;
    while (busy !== val && k < max_cyc) begin
      tick(1);
      k++;
    end
    check(name, 32'(busy), 32'(val));
  endtask

  // tgt < 0: power-on (every target held); tgt >= NT: no target pins move.
  function automatic exp_t mk_exp(input int tgt, input int en, input int io0, input int blen, input bit bt);
    exp_t x = '0;
    for (int i = 0; i < NT; i++) begin
      if (tgt < 0 || tgt == i) begin
        x.en_low[i]  = 8'(en);
        x.io0_low[i] = 8'(io0);
      end
    end
    x.busy_len = 8'(blen);
    x.booted   = bt;
    return x;
  endfunction

  // Completion monitor: accumulates pin-low cycles while busy, scores on busy falling.
  logic busy_prev;
  int   busy_cnt;
  int   en_cnt  [NT];
  int   io0_cnt [NT];

  always @(negedge clk) begin
    if (!rst_n) begin
      busy_prev = 1'b0;
      busy_cnt  = 0;
      for (int i = 0; i < NT; i++) begin en_cnt[i] = 0; io0_cnt[i] = 0; end
    end else begin
      if (busy) begin
        busy_cnt++;
        for (int i = 0; i < NT; i++) begin
          if (!esp_en[i])  en_cnt[i]++;
          if (!esp_io0[i]) io0_cnt[i]++;
        end
      end else if (busy_prev) begin
        n_seq++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_seq: %0d-cycle sequence completed, none expected (t=%0t)", busy_cnt, $time);
        end else begin
          e = exp_q.pop_front();
          check("busy_len", 32'(busy_cnt), 32'(e.busy_len));
          for (int i = 0; i < NT; i++) begin
            check($sformatf("en_low[%0d]", i), 32'(en_cnt[i]), 32'(e.en_low[i]));
            check($sformatf("io0_low[%0d]", i), 32'(io0_cnt[i]), 32'(e.io0_low[i]));
          end
          check("booted_dl", 32'(booted), 32'(e.booted));
        end
        busy_cnt = 0;
        for (int i = 0; i < NT; i++) begin en_cnt[i] = 0; io0_cnt[i] = 0; end
      end
      busy_prev = busy;
    end
  end

  logic [NT-1:0] exp_rx;
  logic          exp_tx;
  logic [2:0]    sels [5];
  int            k;

  initial begin
    //          mode sel  boot press rts dtr seq en io0 busy booted
    vecs[0] = '{2'd0, 3'd2, 1'b1, 12, 0,  1'b0, 1, 20, 30, 30, 1'b1};
    vecs[1] = '{2'd0, 3'd0, 1'b0, 12, 0,  1'b0, 1, 20, 0,  20, 1'b0};
    vecs[2] = '{2'd0, 3'd1, 1'b0, 5,  0,  1'b0, 0, 0,  0,  0,  1'b0};
    vecs[3] = '{2'd1, 3'd3, 1'b0, 0,  40, 1'b1, 1, 40, 50, 50, 1'b1};
    vecs[4] = '{2'd1, 3'd1, 1'b0, 0,  30, 1'b0, 1, 30, 0,  30, 1'b0};
    vecs[5] = '{2'd1, 3'd0, 1'b0, 0,  10, 1'b0, 1, 20, 0,  20, 1'b0};
    vecs[6] = '{2'd1, 3'd2, 1'b0, 12, 0,  1'b0, 1, 20, 0,  20, 1'b0};
    vecs[7] = '{2'd2, 3'd0, 1'b0, 12, 30, 1'b1, 0, 0,  0,  0,  1'b0};
    vecs[8] = '{2'd3, 3'd0, 1'b0, 12, 0,  1'b0, 0, 0,  0,  0,  1'b0};
    vecs[9] = '{2'd0, 3'd5, 1'b1, 12, 0,  1'b0, 1, 0,  0,  30, 1'b1};
    sels[0] = 3'd0; sels[1] = 3'd1; sels[2] = 3'd2; sels[3] = 3'd3; sels[4] = 3'd5;

    rst_n = 1'b1; mode = 2'd0; sel = 3'd0; rst_btn = 1'b0; boot_btn = 1'b0;
    hdr_rx = 1'b1; dtrn = 1'b1; rtsn = 1'b1; esp_tx = '1;
    #1 rst_n = 1'b0;
    tick(3);

    // Reset values and power-on sequence
    check("rst_en", 32'(esp_en), 32'h0);
    check("rst_io0", 32'(esp_io0), 32'hF);
    check("rst_rx", 32'(esp_rx), 32'hF);
    check("rst_tx", 32'(hdr_tx), 32'h1);
    check("rst_busy", 32'(busy), 32'h1);
    check("rst_booted", 32'(booted), 32'h0);
    exp_q.push_back(mk_exp(-1, 20, 0, 20, 1'b0));
    rst_n = 1'b1;
    wait_busy(1'b0, 40, "por_done");
    tick(2);
    check("por_en", 32'(esp_en), 32'hF);
    check("por_io0", 32'(esp_io0), 32'hF);

    // UART mux across selects, including an out-of-range one
    foreach (sels[j]) begin
      sel = sels[j];
      tick(2);
      hdr_rx = 1'b0;
      if (sels[j] < 3'(NT)) begin
        esp_tx = ~(NT'(1) << sels[j]);
        exp_rx = ~(NT'(1) << sels[j]);
        exp_tx = 1'b0;
      end else begin
        esp_tx = '0;
        exp_rx = '1;
        exp_tx = 1'b1;
      end
      #1;
      check($sformatf("uart_rx sel%0d", sels[j]), 32'(esp_rx), 32'(exp_rx));
      check($sformatf("uart_tx sel%0d", sels[j]), 32'(hdr_tx), 32'(exp_tx));
      hdr_rx = 1'b1;
      esp_tx = '1;
    end

    for (int v = 0; v < NV; v++) begin
      cv = vecs[v];
      mode = cv.mode;
      sel  = cv.sel;
      tick(3);
      if (cv.boot) begin boot_btn = 1'b1; tick(12); end
      if (cv.seq != 0) exp_q.push_back(mk_exp(int'(cv.sel), cv.en, cv.io0, cv.busy_len, cv.booted));
      n_before = n_seq;
      if (cv.press > 0) begin rst_btn = 1'b1; tick(cv.press); rst_btn = 1'b0; end
      if (cv.rts > 0) begin dtrn = ~cv.dtr; rtsn = 1'b0; tick(cv.rts); rtsn = 1'b1; end
      tick(120);
      boot_btn = 1'b0;
      dtrn = 1'b1;
      tick(20);
      check($sformatf("v%0d seq_count", v), 32'(n_seq - n_before), 32'(cv.seq));
      check($sformatf("v%0d en_idle", v), 32'(esp_en), 32'hF);
      check($sformatf("v%0d io0_idle", v), 32'(esp_io0), 32'hF);
      check($sformatf("v%0d busy_idle", v), 32'(busy), 32'h0);
    end

    // Reset pulse in the middle of BOOT_HOLD returns to reset values, then power-on runs
    mode = 2'd0; sel = 3'd2;
    tick(3);
    boot_btn = 1'b1;
    tick(12);
    rst_btn = 1'b1;
    tick(12);
    rst_btn = 1'b0;
    k = 0;
    while (!(busy === 1'b1 && esp_en[2] === 1'b1) && k < 60) begin tick(1); k++; end
    check("boot_hold_reached", 32'(esp_io0[2]), 32'h0);
    tick(2);
    rst_n = 1'b0;
    #2;
    check("midrst_en", 32'(esp_en), 32'h0);
    check("midrst_io0", 32'(esp_io0), 32'hF);
    check("midrst_busy", 32'(busy), 32'h1);
    check("midrst_booted", 32'(booted), 32'h0);
    boot_btn = 1'b0;
    tick(3);
    exp_q.push_back(mk_exp(-1, 20, 0, 20, 1'b0));
    rst_n = 1'b1;
    wait_busy(1'b0, 40, "midrst_por_done");
    tick(12);

    // Select change mid-sequence: pins and UART stay on the captured target until IDLE
    sel = 3'd1;
    hdr_rx = 1'b0;
    esp_tx = 4'b1101;
    tick(3);
    exp_q.push_back(mk_exp(1, 20, 0, 20, 1'b0));
    rst_btn = 1'b1;
    tick(12);
    rst_btn = 1'b0;
    wait_busy(1'b1, 30, "selchg_busy");
    sel = 3'd3;
    tick(3);
    check("selchg_en", 32'(esp_en), 32'b1101);
    check("selchg_rx_old", 32'(esp_rx), 32'b1101);
    check("selchg_tx_old", 32'(hdr_tx), 32'h0);
    wait_busy(1'b0, 40, "selchg_done");
    tick(2);
    check("selchg_rx_new", 32'(esp_rx), 32'b0111);
    check("selchg_tx_new", 32'(hdr_tx), 32'h1);
    hdr_rx = 1'b1;
    esp_tx = '1;
    tick(5);

    check("sb_drain", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
